// File: rtl/fft_unload_ctrl_if.sv
// Memory read port plus streamed output port of the FFT unload sequencer.
// Latency: none, this is wiring only.
// Backpressure: out_ready from the consumer; the memory side has no stall.
interface fft_unload_ctrl_if #(
    parameter int N             = 32,
    parameter int word_size     = 16,
    parameter int address_width = $clog2(N)
) ();
    logic                     rd_en;
    logic [address_width-1:0] rd_addr1;
    logic [address_width-1:0] rd_addr2;
    logic [2*word_size-1:0]   rd_samp1;
    logic [2*word_size-1:0]   rd_samp2;
    logic [2*word_size-1:0]   out_data;
    logic [address_width-1:0] out_index;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;

    // Sequencer side: drives the memory and the output stream.
    modport master (
        output rd_en, rd_addr1, rd_addr2,
        input  rd_samp1, rd_samp2,
        output out_data, out_index, out_valid, out_last,
        input  out_ready
    );

    // Memory and consumer side.
    modport slave (
        input  rd_en, rd_addr1, rd_addr2,
        output rd_samp1, rd_samp2,
        input  out_data, out_index, out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/fft_unload_ctrl.sv
// Unloads an N-point FFT result RAM as paired reads and streams one sample per cycle; FFT_UNLOAD_BITREV_EN selects bit-reversed RAM addressing.
// Latency: start at edge 0, first read in cycle 1, first output sample in cycle 3, done one cycle after the last handshake.
// Backpressure: out_ready low holds the output; reads stop once buffered plus in-flight pairs reach BUF_DEPTH.
module fft_unload_ctrl #(
    parameter int N             = 32,
    parameter int word_size     = 16,
    parameter int address_width = $clog2(N),
    parameter int BUF_DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    fft_unload_ctrl_if.master    bus,
    output logic                 busy,
    output logic                 done
);
    localparam int PW = address_width - 1;
    localparam int BW = $clog2(BUF_DEPTH);
    localparam int DW = 2 * word_size;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   rd_pair;     // next pair to read from the RAM
    logic [PW-1:0]   out_pair;    // pair currently at the buffer head
    logic            out_slot;    // 0: emitting slot1, 1: emitting slot2
    logic            inflight;    // a read was issued last cycle, data arrives now
    logic [BW:0]     count;       // pairs held in the buffer
    logic [BW-1:0]   wptr, rptr;
    logic [BW+1:0]   occ;
    logic            credit, hs, pop;
    logic [DW-1:0]   buf1 [BUF_DEPTH];
    logic [DW-1:0]   buf2 [BUF_DEPTH];

    // A read may only go out when its landing slot is already guaranteed.
    assign occ    = {1'b0, count} + {{(BW+1){1'b0}}, inflight};
    assign credit = occ < (BW+2)'(BUF_DEPTH);
    assign hs     = bus.out_valid && bus.out_ready;
    assign pop    = hs && out_slot;

`ifdef FFT_UNLOAD_BITREV_EN
    function automatic logic [address_width-1:0] bitrev(input logic [address_width-1:0] a);
        logic [address_width-1:0] r;
        for (int b = 0; b < address_width; b++) r[b] = a[address_width-1-b];
        return r;
    endfunction

    assign bus.rd_addr1 = bitrev({rd_pair, 1'b0});
    assign bus.rd_addr2 = bitrev({rd_pair, 1'b1});
`else
    assign bus.rd_addr1 = {rd_pair, 1'b0};
    assign bus.rd_addr2 = {rd_pair, 1'b1};
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and read strobe; the last read hands over to DRAIN.
    always_comb begin
        state_nxt  = state;
        bus.rd_en  = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = READ;
            READ:  if (credit) begin
                       bus.rd_en = 1'b1;
                       if (rd_pair == PW'(N/2 - 1)) state_nxt = DRAIN;
                   end
            DRAIN: if (hs && bus.out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Output view of the buffer head; zeroed while nothing is buffered.
    always_comb begin
        bus.out_valid = (count != '0);
        bus.out_data  = '0;
        bus.out_index = '0;
        bus.out_last  = 1'b0;
        if (bus.out_valid) begin
            bus.out_data  = out_slot ? buf2[rptr] : buf1[rptr];
            bus.out_index = {out_pair, out_slot};
            bus.out_last  = &{out_pair, out_slot};
        end
    end

    // Address/index counters, buffer occupancy and the done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pair  <= '0;
            out_pair <= '0;
            out_slot <= 1'b0;
            inflight <= 1'b0;
            count    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            done     <= 1'b0;
        end else begin
            inflight <= bus.rd_en;
            done     <= (state == DRAIN) && hs && bus.out_last;
            if (state == IDLE && start) begin
                rd_pair  <= '0;
                out_pair <= '0;
                out_slot <= 1'b0;
            end else begin
                if (bus.rd_en) rd_pair <= rd_pair + 1'b1;
                if (hs) begin
                    out_slot <= ~out_slot;
                    if (out_slot) out_pair <= out_pair + 1'b1;
                end
            end
            if (inflight) wptr <= wptr + 1'b1;
            if (pop)      rptr <= rptr + 1'b1;
            count <= count + {{BW{1'b0}}, inflight} - {{BW{1'b0}}, pop};
        end
    end

    // Pair buffer storage, written the cycle after each read strobe.
    always_ff @(posedge clk) begin
        if (inflight) begin
            buf1[wptr] <= bus.rd_samp1;
            buf2[wptr] <= bus.rd_samp2;
        end
    end
endmodule

// File: doc/fft_unload_ctrl.md
# fft_unload_ctrl

Sequencer that unloads a completed N-point FFT result from the dual-port result memory and streams it out one complex sample per cycle over a valid/ready interface. It issues paired read addresses (even/odd) to the memory, absorbs the 1-cycle read latency in a small pair buffer under credit control, and serializes each pair onto the output with index and last markers. It sits between the FFT core's result RAM and the downstream consumer, and replaces free-running address stepping with a backpressure-safe unload.

## Interface
- N, 32, FFT length; power of two, >= 4
- word_size, 16, bits per real/imag component
- address_width, $clog2(N), sample address width
- BUF_DEPTH, 4, pair-buffer depth in pairs; power of two, >= 2

- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to unload; ignored while busy
- rd_en  out  1  read strobe to result memory
- rd_addr1  out  address_width  even-slot read address
- rd_addr2  out  address_width  odd-slot read address
- rd_samp1  in  2*word_size  memory data for rd_addr1, valid 1 cycle after rd_en
- rd_samp2  in  2*word_size  memory data for rd_addr2, valid 1 cycle after rd_en
- out_data  out  2*word_size  streamed sample, {real, imag}
- out_index  out  address_width  natural-order frequency index of out_data
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when high with out_valid
- out_last  out  1  high with the sample at index N-1
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse after final handshake

## Operation
- Reset values: rd_en=0, rd_addr1=0, rd_addr2=1, out_data=0, out_index=0, out_valid=0, out_last=0, busy=0, done=0; buffer empty, pair counter 0.
- States: IDLE, READ, DRAIN.
  - IDLE: start=1 -> READ, busy=1; pair counter p=0.
  - READ: rd_en=1 in a cycle iff credits available (buffered pairs + in-flight read < BUF_DEPTH); addresses from p (rd_addr1=2p, rd_addr2=2p+1); p increments per issued read. After issuing p=N/2-1 -> DRAIN.
  - DRAIN: no reads; when the index N-1 sample handshakes -> IDLE, busy=0, done=1 for one cycle.
- Read data captured into the pair buffer on the cycle after rd_en; no read issued without a guaranteed free slot (buffer never overflows).
- Serializer: head pair emitted as slot1 then slot2; pair popped after slot2 handshake. out_index = 2p or 2p+1 of the emitted slot.
- out_valid held, out_data/out_index/out_last stable while out_ready=0.
- start during busy: ignored, no effect on counters.
- reset_n asserted mid-unload: immediate return to reset values; partial frame discarded; no done.
- p and indices wrap-free: exactly N/2 reads and N output samples per start.

## Timing
- start sampled at edge 0 -> first rd_en during cycle 1 (addresses 0,1) -> data in buffer at edge 2 -> out_valid=1 from cycle 3 (index 0).
- out_ready held high: one sample per cycle, no bubbles; reads then issue every other cycle at steady state.
- Frame of N samples with no backpressure: last handshake at cycle N+2; done high cycle N+3; busy low from cycle N+3.
- Next start accepted in the done cycle or later.

## Configuration
- FFT_UNLOAD_BITREV_EN defined: result memory holds bit-reversed order; rd_addr1=bitrev(2p), rd_addr2=bitrev(2p+1) over address_width bits; out_index remains natural order 2p/2p+1.
- Undefined: rd_addr1=2p, rd_addr2=2p+1 (natural order); no bit-reversal logic.

## Test plan
- Reset then start, out_ready=1, N=32, memory word = address: 32 samples indices 0..31, data 0..31, out_last only at index 31, done at cycle 35.
- out_ready low for cycles 5-14 mid-frame: out_data/out_index held, rd_en never issued when buffer+in-flight = 4, no sample lost or duplicated.
- out_ready toggling random 50%: output sequence still 0..31 in order, exactly one done.
- start pulsed again at cycle 10 while busy: ignored; still 32 samples, one done.
- reset_n low at cycle 12: all outputs to reset values same cycle; new start after release yields full frame from index 0.
- FFT_UNLOAD_BITREV_EN defined, N=8, memory word = address: rd_addr pairs (0,4),(2,6),(1,5),(3,7); out_data 0,4,2,6,1,5,3,7 with out_index 0..7.
